// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word per instruction over a
// read-address/read-data bus, and hands {instF, pcF, snpcF, fault} to decode.
//
// state    | meaning
// ---------+------------------------------------------------------------
// REQ      | arvalid high with araddr = pc; waits for arready
// RESP     | rready high; captures rdata/fault on rvalid
// OUT      | m_valid high with a frozen payload; waits for m_ready
// WAIT_NPC | npc_ready high; loads pc from npc on npc_valid
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] instF,
  output logic [31:0] pcF,
  output logic [31:0] snpcF,
  output logic        fault,
  output logic        m_valid,
  input  logic        m_ready,
  input  logic [31:0] npc,
  input  logic        npc_valid,
  output logic        npc_ready
);

  typedef enum logic [1:0] {
    S_REQ      = 2'd0,
    S_RESP     = 2'd1,
    S_OUT      = 2'd2,
    S_WAIT_NPC = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        fault_q, fault_d;
  logic        misaligned;

  assign misaligned = (pc_q[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

  // Handshake outputs are a pure state decode, forced low while in reset so
  // nothing downstream sees a request that the reset is about to abandon.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    fault_d   = fault_q;
    arvalid   = 1'b0;
    rready    = 1'b0;
    m_valid   = 1'b0;
    npc_ready = 1'b0;
    case (state_q)
      S_REQ: begin
        arvalid = ~rst;
        if (arready) state_d = S_RESP;
      end
      S_RESP: begin
        rready = ~rst;
        if (rvalid) begin
          inst_d  = rdata;
          fault_d = (rresp != 2'b00) | misaligned;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        m_valid = ~rst;
        if (m_ready) state_d = S_WAIT_NPC;
      end
      S_WAIT_NPC: begin
        npc_ready = ~rst;
        if (npc_valid) begin
          pc_d    = npc;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign araddr = pc_q;
  assign pcF    = pc_q;
  assign snpcF  = pc_q + 32'd4;
  assign instF  = inst_q;
  assign fault  = fault_q;

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the multi-cycle NPC core. It owns the architectural PC and reads one instruction word per fetch over a read-address/read-data bus. It hands {instF, pcF, snpcF} to the F->D stage register through a valid/ready handshake, then waits for the next PC from the back end before fetching again. It is the producer end of the fetch-to-decode interface.

## Interface

- RESET_PC, 32'h80000000, PC value loaded on reset
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- araddr  out  32  fetch address; equals pc
- arvalid  out  1  read-address request valid
- arready  in  1  read-address accepted by the bus
- rdata  in  32  returned instruction word
- rresp  in  2  read response; 2'b00 = OKAY, anything else = error
- rvalid  in  1  read data valid
- rready  out  1  fetch unit ready for read data
- instF  out  32  fetched instruction, registered
- pcF  out  32  PC of instF
- snpcF  out  32  static next PC, pcF + 4
- fault  out  1  access fault on this fetch (rresp != 0 or pc[1:0] != 0)
- m_valid  out  1  {instF, pcF, snpcF, fault} valid toward decode (drives the decode register's s_valid)
- m_ready  in  1  decode register ready (its s_ready)
- npc  in  32  next PC from writeback
- npc_valid  in  1  npc valid
- npc_ready  out  1  fetch unit ready to accept npc

## Operation

- FSM states: REQ, RESP, OUT, WAIT_NPC. Reset state is REQ.
- REQ: arvalid = 1. On arvalid & arready, go to RESP.
- RESP: rready = 1. On rvalid:
  - capture instF <= rdata and fault <= (rresp != 0) | (pc[1:0] != 0);
  - go to OUT.
- OUT: m_valid = 1. On m_ready, go to WAIT_NPC. The payload is frozen while m_valid = 1.
- WAIT_NPC: npc_ready = 1. On npc_valid, load pc <= npc and go to REQ.
- Every handshake output is a pure decode of the state, gated to 0 while rst = 1. Only one of arvalid, rready, m_valid, npc_ready is high in any cycle.
- pcF = pc and araddr = pc.
- snpcF = pc + 32'd4, computed modulo 2^32: pc = 32'hFFFFFFFC gives snpcF = 32'h00000000.
- A misaligned pc is still fetched as-is; the fault bit flags it. Fault handling belongs downstream.
- Inputs outside their state are ignored, with no latching:
  - rvalid in REQ;
  - m_ready in REQ/RESP/WAIT_NPC;
  - npc_valid outside WAIT_NPC.
- Reset mid-operation:
  - any outstanding bus transaction is abandoned and no response is awaited;
  - the state returns to REQ;
  - pc <= RESET_PC, instF <= 0, fault <= 0.

## Timing

- Reset values, in the cycle after rst:
  - pc = RESET_PC, araddr = RESET_PC, snpcF = RESET_PC + 4;
  - instF = 0, fault = 0, arvalid = 1;
  - rready = m_valid = npc_ready = 0.
- During rst = 1, all four handshake outputs are 0.
- Minimum cost is 4 cycles per instruction, with arready, rvalid, m_ready and npc_valid each high on first sight: REQ, RESP, OUT, WAIT_NPC.
- The bus may stall arbitrarily in REQ or RESP. arvalid and araddr stay stable until arready.
- instF and fault are visible in the cycle after the rvalid handshake, together with m_valid = 1.
- A new pc is visible on araddr/pcF in the cycle after the npc handshake.
- Consecutive handshakes may never complete in the same cycle. Example: rvalid and m_ready both high in RESP means m_ready is ignored.

## Test plan

- Reset release, all slaves always ready, rdata = 32'h00000013 -> arvalid at cycle 1 with araddr = 32'h80000000; m_valid at cycle 3 with instF = 32'h00000013 and snpcF = 32'h80000004; after npc = 32'h80000004 in cycle 4, araddr = 32'h80000004 at cycle 5.
- arready held low 5 cycles, then rvalid delayed 3 cycles -> arvalid and araddr stable throughout; exactly one capture; m_valid rises 1 cycle after the rvalid handshake.
- m_ready low 10 cycles while in OUT, rdata toggling on the bus -> instF, pcF and m_valid held unchanged until m_ready.
- rresp = 2'b10 on fetch -> fault = 1 with m_valid; next fetch with OKAY -> fault = 0. npc = 32'h80000002 -> fault = 1 on that fetch.
- npc = 32'hFFFFFFFC -> snpcF = 32'h00000000. npc_valid pulsed during OUT -> ignored and pc unchanged.
- rst asserted during RESP with rvalid pending -> next cycle pc = 32'h80000000, arvalid = 1, instF = 0, rready = 0.
